// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - task FIFO feeding round-robin per-core load/wake/run FSMs; optional watchdog via CORE_SCHED_WATCHDOG_EN
module core_scheduler #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 32,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          task_valid,
  output logic                          task_ready,
  input  logic [ADDR_W-1:0]             task_pc,
  input  logic                          task_rt,
  input  logic [NUM_CORES-1:0]          core_exit,
  output logic [NUM_CORES*ADDR_W-1:0]   core_pc,
  output logic [NUM_CORES-1:0]          core_pc_load,
  output logic [NUM_CORES-1:0]          core_wake,
  output logic [NUM_CORES-1:0]          core_rt,
  output logic [NUM_CORES-1:0]          core_busy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic [15:0]                   done_count,
  output logic [NUM_CORES-1:0]          timeout_flag
);
  localparam int QPTR_W = $clog2(QUEUE_DEPTH);
  localparam int CPTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int FCNT_W = $clog2(NUM_CORES) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAKE, RUN} coreState_t;

  coreState_t        coreState [NUM_CORES];
  logic [ADDR_W-1:0] qPc [QUEUE_DEPTH];
  logic              qRt [QUEUE_DEPTH];
  logic [QPTR_W-1:0] rdPtr;
  logic [QPTR_W-1:0] wrPtr;
  logic [CPTR_W-1:0] rrPtr;

  logic              push;
  logic              pop;
  logic              anyIdle;
  logic [CPTR_W-1:0] pickIdx;
  int                scanIdx;
  logic [NUM_CORES-1:0] finish;
  logic [FCNT_W-1:0]    finishCnt;
  logic [NUM_CORES-1:0] timeoutHit;

  // Timeout must be a positive cycle count; only the watchdog build consumes it.
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
  end

  assign task_ready = (queue_count != (QPTR_W+1)'(QUEUE_DEPTH));
  assign push       = task_valid && task_ready;
  // Dispatch looks only at registered state, so a task pushed this edge cannot be popped this edge.
  assign pop        = anyIdle && (queue_count != '0);

  // Round-robin scan: first IDLE core at or above rrPtr, wrapping.
  always_comb begin
    anyIdle = 1'b0;
    pickIdx = '0;
    scanIdx = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scanIdx = (int'(rrPtr) + k) % NUM_CORES;
      if (!anyIdle && coreState[scanIdx] == IDLE) begin
        anyIdle = 1'b1;
        pickIdx = CPTR_W'(scanIdx);
      end
    end
  end

  // Completions this edge: only RUN cores honour their exit strobe.
  always_comb begin
    finishCnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      finish[i] = (coreState[i] == RUN) && core_exit[i];
      finishCnt = finishCnt + FCNT_W'(finish[i]);
    end
  end

  // Busy is simply "not IDLE".
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      core_busy[i] = (coreState[i] != IDLE);
    end
  end

  // FIFO payload storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      qPc[wrPtr] <= task_pc;
      qRt[wrPtr] <= task_rt;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      queue_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      queue_count <= queue_count + 1'b1;
      else if (pop && !push) queue_count <= queue_count - 1'b1;
    end
  end

  // Per-core FSMs with registered strobes, latched task fields and completion counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) coreState[i] <= IDLE;
      core_pc      <= '0;
      core_rt      <= '0;
      core_pc_load <= '0;
      core_wake    <= '0;
      rrPtr        <= '0;
      done_count   <= '0;
    end else begin
      done_count <= done_count + 16'(finishCnt);
      if (pop) rrPtr <= (int'(pickIdx) == NUM_CORES - 1) ? '0 : pickIdx + 1'b1;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_pc_load[i] <= 1'b0;
        core_wake[i]    <= 1'b0;
        case (coreState[i])
          IDLE: if (pop && pickIdx == CPTR_W'(i)) begin
            coreState[i]                 <= LOAD;
            core_pc[i*ADDR_W +: ADDR_W]  <= qPc[rdPtr];
            core_rt[i]                   <= qRt[rdPtr];
            core_pc_load[i]              <= 1'b1;
          end
          LOAD: begin
            coreState[i] <= WAKE;
            core_wake[i] <= 1'b1;
          end
          WAKE: coreState[i] <= RUN;
          RUN:  if (finish[i] || timeoutHit[i]) coreState[i] <= IDLE;
          default: coreState[i] <= IDLE;
        endcase
      end
    end
  end

`ifdef CORE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] runCnt [NUM_CORES];

  // Watchdog fires when a RUN core reaches the limit; a simultaneous exit wins.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      timeoutHit[i] = (coreState[i] == RUN) && !core_exit[i] &&
                      (runCnt[i] == WD_W'(TIMEOUT_CYCLES));
    end
  end

  // RUN-cycle counters start at 1 on entry; flags stay set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) runCnt[i] <= '0;
      timeout_flag <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (coreState[i] == WAKE) runCnt[i] <= WD_W'(1);
        else if (coreState[i] == RUN && runCnt[i] != WD_W'(TIMEOUT_CYCLES)) runCnt[i] <= runCnt[i] + 1'b1;
        if (timeoutHit[i]) timeout_flag[i] <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit   = '0;
  assign timeout_flag = '0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - randomized and directed bench for core_scheduler against a task-age reference model
module tb_core_scheduler;
  localparam int NC = 4;
  localparam int AW = 32;
  localparam int QD = 4;
  localparam int TO = 16;
`ifdef CORE_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            task_valid;
  logic            task_ready;
  logic [AW-1:0]   task_pc;
  logic            task_rt;
  logic [NC-1:0]   core_exit;
  logic [NC*AW-1:0] core_pc;
  logic [NC-1:0]   core_pc_load, core_wake, core_rt, core_busy;
  logic [2:0]      queue_count;
  logic [15:0]     done_count;
  logic [NC-1:0]   timeout_flag;

  core_scheduler #(.NUM_CORES(NC), .ADDR_W(AW), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .task_valid(task_valid), .task_ready(task_ready),
    .task_pc(task_pc), .task_rt(task_rt), .core_exit(core_exit), .core_pc(core_pc),
    .core_pc_load(core_pc_load), .core_wake(core_wake), .core_rt(core_rt),
    .core_busy(core_busy), .queue_count(queue_count), .done_count(done_count),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Reference model: a core is described by cycles since dispatch (-1 = idle).
  typedef struct { logic [AW-1:0] pc; logic rt; } task_t;
  task_t        mQ[$];
  int           mAge [NC];
  logic [AW-1:0] mPc [NC];
  logic         mRt [NC];
  int           mRr;
  int           mDone;
  logic [NC-1:0] mTo;
  bit           mLastAcc;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mQ.delete();
    for (int i = 0; i < NC; i++) begin
      mAge[i] = -1; mPc[i] = '0; mRt[i] = 1'b0;
    end
    mRr = 0; mDone = 0; mTo = '0; mLastAcc = 1'b0;
  endfunction

  function automatic bit modelBusy();
    for (int i = 0; i < NC; i++) if (mAge[i] >= 0) return 1'b1;
    return 1'b0;
  endfunction

  // One rising edge: everything decided from the state before the edge.
  function automatic void modelEdge();
    int pick = -1;
    task_t t;
    mLastAcc = task_valid && (mQ.size() != QD);
    if (mQ.size() != 0)
      for (int k = 0; k < NC; k++)
        if (pick < 0 && mAge[(mRr + k) % NC] < 0) pick = (mRr + k) % NC;
    for (int i = 0; i < NC; i++) begin
      if (mAge[i] >= 2 && core_exit[i]) begin
        mDone = (mDone + 1) % 65536;
        mAge[i] = -1;
      end else if (WD && mAge[i] >= 2 && mAge[i] - 1 == TO) begin
        mAge[i] = -1;
        mTo[i] = 1'b1;
      end else if (mAge[i] >= 0) begin
        mAge[i]++;
      end
    end
    if (pick >= 0) begin
      t = mQ.pop_front();
      mAge[pick] = 0; mPc[pick] = t.pc; mRt[pick] = t.rt;
      mRr = (pick + 1) % NC;
    end
    if (mLastAcc) begin
      t.pc = task_pc; t.rt = task_rt;
      mQ.push_back(t);
    end
  endfunction

  task automatic checkAll();
    for (int i = 0; i < NC; i++) begin
      check($sformatf("pc_load[%0d]", i), 64'(core_pc_load[i]), 64'(mAge[i] == 0));
      check($sformatf("wake[%0d]", i), 64'(core_wake[i]), 64'(mAge[i] == 1));
      check($sformatf("busy[%0d]", i), 64'(core_busy[i]), 64'(mAge[i] >= 0));
      check($sformatf("rt[%0d]", i), 64'(core_rt[i]), 64'(mRt[i]));
      check($sformatf("pc[%0d]", i), 64'(core_pc[i*AW +: AW]), 64'(mPc[i]));
    end
    check("queue_count", 64'(queue_count), 64'(mQ.size()));
    check("done_count", 64'(done_count), 64'(mDone));
    check("task_ready", 64'(task_ready), 64'(mQ.size() != QD));
    check("timeout_flag", 64'(timeout_flag), 64'(mTo));
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic rt, input logic [NC-1:0] ex);
    task_valid = v; task_pc = pc; task_rt = rt; core_exit = ex;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drainAll();
    int n = 0;
    task_valid = 1'b0;
    while ((modelBusy() || mQ.size() != 0) && n < 60) begin
      core_exit = '1;
      step();
      n++;
    end
    core_exit = '0;
    check("drain_busy", 64'(core_busy), 64'(0));
    check("drain_queue", 64'(queue_count), 64'(0));
  endtask

  initial begin
    logic [AW-1:0] offerPc;
    drive(1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    modelReset();
    #2;
    checkAll();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single task lands on core 0.
    drive(1'b1, 32'h100, 1'b1, '0);
    step();
    idle(4);
    check("single_pc0", 64'(core_pc[AW-1:0]), 64'h100);
    drainAll();

    // Five back-to-back tasks; fifth waits, then goes to core 2 after its exit.
    doReset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 1'(i), '0);
      step();
    end
    idle(4);
    check("five_q1", 64'(queue_count), 64'(1));
    drive(1'b0, '0, 1'b0, 4'b0100);
    step();
    idle(4);
    check("five_core2_pc", 64'(core_pc[2*AW +: AW]), 64'h204);
    drainAll();

    // Saturating offers: queue fills to four and the ninth offer is held.
    offerPc = 32'h300;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, offerPc, 1'b0, '0);
      step();
      if (mLastAcc) offerPc++;
    end
    check("full_ready", 64'(task_ready), 64'(0));
    check("full_count", 64'(queue_count), 64'(4));
    drainAll();

    // Simultaneous exits count twice; exits on idle cores count nothing.
    doReset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 1'b0, '0);
      step();
    end
    idle(5);
    drive(1'b0, '0, 1'b0, 4'b1010);
    step();
    check("dual_exit_done", 64'(done_count), 64'(2));
    step();
    check("idle_exit_done", 64'(done_count), 64'(2));
    drainAll();

    // Reset while core 0 is in WAKE with two tasks queued.
    doReset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b1, '0);
      step();
    end
    idle(3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(i), 1'b0, '0);
      step();
    end
    drive(1'b0, '0, 1'b0, 4'b0001);
    step();
    idle(2);
    check("pre_reset_wake", 64'(core_wake[0]), 64'(1));
    check("pre_reset_q", 64'(queue_count), 64'(2));
    doReset();
    check("post_reset_q", 64'(queue_count), 64'(0));
    drive(1'b1, 32'h700, 1'b1, '0);
    step();
    check("first_edge_accept", 64'(queue_count), 64'(1));
    drainAll();

    // Core that never exits: watchdog build returns it to IDLE with a flag.
    doReset();
    drive(1'b1, 32'h800, 1'b0, '0);
    step();
    idle(25);
    drainAll();

    // Randomized traffic with sparse exits and occasional resets.
    for (int n = 0; n < 800; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), '0);
      for (int i = 0; i < NC; i++) core_exit[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) doReset();
      else step();
    end
    drainAll();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
